// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in / serial-out serializer.
package piso_pkg;

  // Default word width in bits; legal values are 2..32.
  localparam int unsigned PISO_DEFAULT_WIDTH = 4;

  // Serializer control states: waiting for a word, or emitting its bits.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_e;

endpackage : piso_pkg

// File: rtl/piso_serializer.sv
// MSB-first parallel-to-serial converter with a valid/ready load port and a
// bit-rate enable. The next word is accepted during the last-bit cycle, so
// frames can be emitted back to back without an idle bit between them.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH = PISO_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             shift_en,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             frame_start,
  output logic             frame_last
);

  // The counter indexes bits 0..WIDTH-1 of the current frame.
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  piso_state_e      state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic inShift;
  logic atLast;
  logic accept;

  assign inShift = (state_q == SHIFT);
  assign atLast  = (cnt_q == LAST_IDX);
  assign accept  = load_valid && load_ready;

  // Handshake and frame flags, all derived from registered state plus shift_en.
  always_comb begin
    load_ready   = 1'b0;
    serial_valid = inShift;
    serial_out   = 1'b0;
    frame_start  = 1'b0;
    frame_last   = 1'b0;
    if (inShift) begin
      load_ready  = atLast && shift_en;
      serial_out  = shift_q[WIDTH-1];
      frame_start = (cnt_q == '0);
      frame_last  = atLast;
    end else begin
      load_ready = 1'b1;
    end
  end

  // Next-state logic: load on accept, shift on enable, finish after the last bit.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          shift_d = parallel_in;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (shift_en) begin
          if (atLast) begin
            cnt_d = '0;
            if (accept) begin
              state_d = SHIFT;
              shift_d = parallel_in;
            end else begin
              state_d = IDLE;
              shift_d = '0;
            end
          end else begin
            shift_d = {shift_q[WIDTH-2:0], 1'b0};
            cnt_d   = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        shift_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // State register; reset aborts any frame in progress immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule : piso_serializer

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer (WIDTH=4): every accepted word pushes its
// expected bits and frame flags, which are popped as the serializer emits them,
// and a SIPO model rebuilds each word from the serial stream.
module tb_piso_serializer;

  logic       clk;
  logic       reset_n;
  logic       load_valid;
  logic       load_ready;
  logic [3:0] parallel_in;
  logic       shift_en;
  logic       serial_out;
  logic       serial_valid;
  logic       frame_start;
  logic       frame_last;

  int checks   = 0;
  int failures = 0;

  // Expected bits as {bit, frame_start, frame_last}, oldest first.
  logic [2:0] bitQ[$];
  logic [3:0] wordQ[$];
  logic [3:0] sipo;
  int         sipoCount;
  int         sipoWords;
  logic       lastAcc;

  piso_serializer #(.WIDTH(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .parallel_in  (parallel_in),
    .shift_en     (shift_en),
    .serial_out   (serial_out),
    .serial_valid (serial_valid),
    .frame_start  (frame_start),
    .frame_last   (frame_last)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so a stuck run still ends with a report.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic clearScoreboard();
    bitQ.delete();
    wordQ.delete();
    sipo      = '0;
    sipoCount = 0;
  endtask

  // One clock cycle: drive just after the rising edge, then at the falling
  // edge check the emitted bit against the scoreboard and record a handshake.
  task automatic doCycle(input logic v, input logic [3:0] w, input logic s);
    logic [2:0] head;
    @(posedge clk);
    #1;
    load_valid  = v;
    parallel_in = w;
    shift_en    = s;
    @(negedge clk);
    lastAcc = load_valid && load_ready;
    if (serial_valid) begin
      if (bitQ.size() == 0) begin
        checkOutput("unexpected_bit", {31'd0, serial_valid}, 0);
      end else begin
        head = bitQ[0];
        checkOutput("serial_out", {31'd0, serial_out}, {31'd0, head[2]});
        checkOutput("frame_start", {31'd0, frame_start}, {31'd0, head[1]});
        checkOutput("frame_last", {31'd0, frame_last}, {31'd0, head[0]});
        if (shift_en) begin
          void'(bitQ.pop_front());
          sipo = {sipo[2:0], serial_out};
          sipoCount++;
          if (sipoCount == 4) begin
            sipoCount = 0;
            sipoWords++;
            if (wordQ.size() == 0) checkOutput("sipo_extra_word", {28'd0, sipo}, 32'hx);
            else checkOutput("sipo_word", {28'd0, sipo}, {28'd0, wordQ.pop_front()});
          end
        end
      end
    end else begin
      checkOutput("idle_outputs", {29'd0, serial_out, frame_start, frame_last}, 0);
    end
    if (lastAcc) begin
      for (int i = 3; i >= 0; i--) bitQ.push_back({w[i], i == 3, i == 0});
      wordQ.push_back(w);
    end
  endtask

  // Keep shifting until the scoreboard is empty and the serializer is idle.
  task automatic drain(input string tag);
    for (int k = 0; k < 40 && (bitQ.size() != 0 || serial_valid); k++) doCycle(1'b0, 4'h0, 1'b1);
    checkOutput({tag, "_drained"}, bitQ.size(), 0);
    checkOutput({tag, "_idle"}, {31'd0, serial_valid}, 0);
  endtask

  task automatic applyStimulus();
    logic [3:0] pat;
    logic [3:0] word;
    logic       got;
    int         accCount;
    int         startWords;
    logic [6:0] stallEn;
    logic [6:0] stallOut;

    // Power-on reset: outputs quiet during reset, ready after release.
    reset_n = 1'b0;
    load_valid = 1'b0; parallel_in = '0; shift_en = 1'b0;
    clearScoreboard();
    sipoWords = 0;
    #3;
    checkOutput("rst_valid", {31'd0, serial_valid}, 0);
    checkOutput("rst_flags", {29'd0, serial_out, frame_start, frame_last}, 0);
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    doCycle(1'b0, 4'h0, 1'b0);
    checkOutput("rst_ready", {31'd0, load_ready}, 1);
    checkOutput("rst_idle", {31'd0, serial_valid}, 0);

    // Single frame 1011 with continuous enable.
    pat = 4'b1011;
    doCycle(1'b1, pat, 1'b1);
    checkOutput("t1_ready_idle", {31'd0, load_ready}, 1);
    for (int i = 1; i <= 4; i++) begin
      doCycle(1'b0, 4'h0, 1'b1);
      checkOutput("t1_bit", {31'd0, serial_out}, {31'd0, pat[4-i]});
      checkOutput("t1_start", {31'd0, frame_start}, (i == 1) ? 1 : 0);
      checkOutput("t1_last", {31'd0, frame_last}, (i == 4) ? 1 : 0);
    end
    doCycle(1'b0, 4'h0, 1'b1);
    checkOutput("t1_back_idle", {31'd0, serial_valid}, 0);
    drain("t1");

    // Back to back 1100 then 0011: no gap, ready only at acceptance cycles.
    doCycle(1'b1, 4'b1100, 1'b1);
    checkOutput("t2_ready0", {31'd0, load_ready}, 1);
    for (int i = 1; i <= 4; i++) begin
      doCycle(1'b1, 4'b0011, 1'b1);
      checkOutput("t2_ready", {31'd0, load_ready}, (i == 4) ? 1 : 0);
      checkOutput("t2_valid", {31'd0, serial_valid}, 1);
    end
    pat = 4'b0011;
    for (int i = 1; i <= 4; i++) begin
      doCycle(1'b0, 4'h0, 1'b1);
      checkOutput("t2_valid2", {31'd0, serial_valid}, 1);
      checkOutput("t2_bit2", {31'd0, serial_out}, {31'd0, pat[4-i]});
    end
    doCycle(1'b0, 4'h0, 1'b1);
    checkOutput("t2_gap_after", {31'd0, serial_valid}, 0);
    drain("t2");

    // Stalls: enable 1,0,0,1,1,0,1 holds each bit while disabled.
    stallEn  = 7'b1001101;
    stallOut = 7'b1000011;
    doCycle(1'b1, 4'b1001, 1'b1);
    for (int i = 6; i >= 0; i--) begin
      doCycle(1'b0, 4'h0, stallEn[i]);
      checkOutput("t3_hold_bit", {31'd0, serial_out}, {31'd0, stallOut[i]});
      checkOutput("t3_valid", {31'd0, serial_valid}, 1);
    end
    doCycle(1'b0, 4'h0, 1'b1);
    checkOutput("t3_done", {31'd0, serial_valid}, 0);
    drain("t3");

    // Loopback: 16 random words through a SIPO model, random enable stalls.
    startWords = sipoWords;
    for (int n = 0; n < 16; n++) begin
      word = 4'($urandom_range(0, 15));
      got  = 1'b0;
      for (int k = 0; k < 30 && !got; k++) begin
        doCycle(1'b1, word, $urandom_range(0, 3) != 0);
        got = lastAcc;
      end
      checkOutput("lb_accept", {31'd0, got}, 1);
    end
    drain("lb");
    checkOutput("lb_words", sipoWords - startWords, 16);

    // Reset mid-frame aborts 1111; a following 0101 serializes cleanly.
    doCycle(1'b1, 4'b1111, 1'b1);
    doCycle(1'b0, 4'h0, 1'b1);
    doCycle(1'b0, 4'h0, 1'b1);
    #2;
    shift_en = 1'b0;
    reset_n  = 1'b0;
    #1;
    checkOutput("t5_abort_valid", {31'd0, serial_valid}, 0);
    checkOutput("t5_abort_outs", {29'd0, serial_out, frame_start, frame_last}, 0);
    clearScoreboard();
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    doCycle(1'b0, 4'h0, 1'b0);
    checkOutput("t5_ready", {31'd0, load_ready}, 1);
    checkOutput("t5_idle", {31'd0, serial_valid}, 0);
    pat = 4'b0101;
    doCycle(1'b1, pat, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      doCycle(1'b0, 4'h0, 1'b1);
      checkOutput("t5_bit", {31'd0, serial_out}, {31'd0, pat[4-i]});
    end
    drain("t5");

    // Busy offer: 0110 held during bits 1-3 of 1010, taken at the last bit.
    doCycle(1'b1, 4'b1010, 1'b1);
    accCount = 0;
    for (int i = 1; i <= 4; i++) begin
      doCycle(1'b1, 4'b0110, 1'b1);
      checkOutput("t6_ready", {31'd0, load_ready}, (i == 4) ? 1 : 0);
      if (lastAcc) accCount++;
    end
    checkOutput("t6_accepts", accCount, 1);
    pat = 4'b0110;
    for (int i = 1; i <= 4; i++) begin
      doCycle(1'b0, 4'h0, 1'b1);
      checkOutput("t6_bit", {31'd0, serial_out}, {31'd0, pat[4-i]});
    end
    drain("t6");
  endtask

  initial begin
    applyStimulus();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_piso_serializer
